sub_serial_digit: RTL and testbench
===================================

// Module: sub_serial_digit
// PURPOSE
//  Digit-serial two's-complement subtractor. It is the inverse-direction companion to
//  the partitioned adder slices: it recovers diff = a - b - bin over DIGIT bits per
//  cycle, with the borrow chained through a register.
//  Sits behind the operand staging logic. Uses a valid/ready handshake on both sides.
//  Used as the exact reference datapath when scoring approximate adder partitions.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of DIGIT
//  DIGIT  4   bits processed per cycle; N = WIDTH/DIGIT cycles per operation
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands a, b, bin valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  minuend
//  b          in   WIDTH  subtrahend
//  bin        in   1      borrow in
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//  bout       out  1      borrow out: 1 iff a < b + bin as unsigned values
//  ovf        out  1      signed overflow: a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]
//  zero       out  1      diff == 0
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0; diff, bout, ovf, zero and the
//    internal a, b, borrow and counter registers all clear to 0.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//  - IDLE: in_ready=1. When in_valid=1, latch a, b and bin. Set borrow=bin and
//    cnt=0. Go to RUN.
//  - RUN: in_ready=0. Each cycle, digit cell k=cnt computes
//    {nb,d} = a[k] - b[k] - borrow over DIGIT bits.
//    Write d into diff[k*DIGIT +: DIGIT], then set borrow<=nb and cnt<=cnt+1.
//    When cnt reaches N-1, that last digit is written and the FSM goes to DONE.
//  - DONE: out_valid=1. bout=borrow. ovf and zero are registered on entry to DONE.
//    diff, bout, ovf and zero hold stable while out_valid=1 and out_ready=0.
//    On out_valid && out_ready: go to IDLE and drop out_valid. diff keeps its value.
//  - Latency: out_valid rises N+1 edges after the accepting edge.
//    Throughput is one operation per N+2 cycles minimum.
//  - in_ready=0 in RUN and DONE; in_valid is ignored there. There is no overlap of
//    operations, and operands cannot be changed mid-flight.
//  - out_ready is a don't-care outside DONE.
//  - cnt width is clog2(N), minimum 1. cnt does not wrap inside RUN.
//  - N=1 (WIDTH==DIGIT) is legal: RUN lasts one cycle.
//  - Reset asserted mid-operation: the operation is dropped and all state returns to
//    reset values immediately. No partial result is presented.
//  - Elaboration error if WIDTH%DIGIT!=0 or DIGIT<1.
// STRUCTURE
//  - Package sub_serial_pkg: state enum {IDLE,RUN,DONE} (2-bit) and the function
//    n_digits(WIDTH,DIGIT).
//  - One sub-module, sub_digit_cell: a combinational DIGIT-bit subtract with borrow
//    in and borrow out, written as a ripple of half-subtractors so it mirrors the
//    adder partitions.
//  - The top level holds the FSM, the counter, the borrow register and the result
//    register.
// TESTING (WIDTH=8, DIGIT=4 unless noted)
//  - a=0x35, b=0x12, bin=0 -> diff=0x23, bout=0, ovf=0, zero=0;
//    out_valid exactly 3 edges after accept.
//  - a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1, ovf=0; the borrow ripples across
//    both digits.
//  - a=0x80, b=0x01, bin=0 -> diff=0x7F, bout=0, ovf=1.
//    a=0x10, b=0x0F, bin=1 -> diff=0x00, zero=1, bout=0.
//  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, and a new
//    in_valid is ignored. Then out_ready=1 -> IDLE on the next edge.
//  - Assert rst_n=0 during RUN cnt=1 -> out_valid=0 and in_ready=1 immediately.
//    The next op 0x35-0x12 then gives a correct 0x23.
//  - Random regression, 10k ops, WIDTH=32 with DIGIT in {1,4,8,32}: compare against a
//    golden model with random in_valid/out_ready gaps.

Source files
------------

// File: rtl/sub_serial_digit_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
// Holds the FSM state encoding and the digit-count function.
package sub_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of digit cycles per operation. A zero digit width returns 1 so the
    // elaboration check in the top can report the error cleanly.
    function automatic int n_digits(input int width, input int digit);
        if (digit < 1) begin
            return 1;
        end
        return width / digit;
    endfunction

endpackage

// File: rtl/sub_serial_digit_if.sv
// Operand and result handshake bundle for sub_serial_digit.
// master = operand producer / result consumer, slave = the subtractor.
interface sub_serial_digit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, ovf, zero
    );
endinterface

// File: rtl/sub_serial_digit_cell.sv
// Combinational DIGIT-bit subtract with borrow in/out, built as a ripple of
// half-subtractor pairs so its structure mirrors the adder partitions.
module sub_digit_cell #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic             i_bin,
    output logic [DIGIT-1:0] o_d,
    output logic             o_bout
);

    logic [DIGIT:0] w_borrow;

    assign w_borrow[0] = i_bin;

    // Each bit: first half-subtractor does a - b, second subtracts the incoming borrow.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic w_hd;
        logic w_hb1;
        logic w_hb2;

        assign w_hd            = i_a[i] ^ i_b[i];
        assign w_hb1           = ~i_a[i] & i_b[i];
        assign o_d[i]          = w_hd ^ w_borrow[i];
        assign w_hb2           = ~w_hd & w_borrow[i];
        assign w_borrow[i + 1] = w_hb1 | w_hb2;
    end

    assign o_bout = w_borrow[DIGIT];

endmodule

// File: rtl/sub_serial_digit.sv
// Digit-serial two's-complement subtractor: diff = a - b - bin, DIGIT bits per
// cycle with the borrow carried in a register between digits.
module sub_serial_digit
    import sub_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sub_serial_digit_if.slave  bus
);

    localparam int N  = n_digits(WIDTH, DIGIT);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("sub_serial_digit: WIDTH must be a positive multiple of DIGIT");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_borrow;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;
    logic             r_ovf;
    logic             r_zero;
    logic             r_out_valid;
    logic             r_in_ready;

    logic [DIGIT-1:0] w_a_dig;
    logic [DIGIT-1:0] w_b_dig;
    logic [DIGIT-1:0] w_d;
    logic             w_nb;
    logic [WIDTH-1:0] w_diff_next;
    logic             w_last;

    // Pick the current operand digits and splice the new result digit in place.
    always_comb begin
        w_a_dig     = '0;
        w_b_dig     = '0;
        w_diff_next = r_diff;
        for (int k = 0; k < N; k++) begin
            if (r_cnt == CW'(k)) begin
                w_a_dig                         = r_a[k*DIGIT +: DIGIT];
                w_b_dig                         = r_b[k*DIGIT +: DIGIT];
                w_diff_next[k*DIGIT +: DIGIT]   = w_d;
            end
        end
    end

    assign w_last = (r_cnt == CW'(N - 1));

    sub_digit_cell #(
        .DIGIT (DIGIT)
    ) u_cell (
        .i_a    (w_a_dig),
        .i_b    (w_b_dig),
        .i_bin  (r_borrow),
        .o_d    (w_d),
        .o_bout (w_nb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a        <= bus.a;
                        r_b        <= bus.b;
                        r_borrow   <= bus.bin;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_diff   <= w_diff_next;
                    r_borrow <= w_nb;
                    // Flags are judged on the completed result, including the last digit.
                    if (w_last) begin
                        r_bout      <= w_nb;
                        r_ovf       <= (r_a[WIDTH-1] != r_b[WIDTH-1]) &&
                                       (w_diff_next[WIDTH-1] != r_a[WIDTH-1]);
                        r_zero      <= (w_diff_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
    assign bus.ovf       = r_ovf;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_sub_serial_digit.sv
// Directed and randomised checks of sub_serial_digit at WIDTH=8, DIGIT=4.
// All sampling and driving happens on the falling clock edge.
module tb_sub_serial_digit;

    localparam int WIDTH = 8;
    localparam int DIGIT = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sub_serial_digit_if #(.WIDTH(WIDTH)) bus ();

    sub_serial_digit #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One full operation; optional latency check, optional hold in DONE with
    // a competing in_valid that the DUT must ignore.
    task automatic applyStimulus(input string tag, input logic [7:0] a, input logic [7:0] b,
                                 input logic bin, input logic [7:0] expDiff,
                                 input logic expBout, input logic expOvf, input logic expZero,
                                 input bit doLatency, input int holdCycles, input bit noise);
        int waitCnt;
        int edges;
        @(negedge clk);
        bus.a         = a;
        bus.b         = b;
        bus.bin       = bin;
        bus.in_valid  = 1'b1;
        bus.out_ready = (holdCycles == 0);
        waitCnt = 0;
        while (!bus.in_ready && waitCnt < 20) begin
            @(negedge clk);
            waitCnt++;
        end
        if (waitCnt >= 20) checkOutput({tag, " accept-timeout"}, 32'd0, 32'd1);
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.out_valid && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (doLatency) checkOutput({tag, " latency"}, 32'(edges), 32'd3);
        checkOutput({tag, " out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        checkOutput({tag, " diff"}, {24'd0, bus.diff}, {24'd0, expDiff});
        checkOutput({tag, " bout"}, {31'd0, bus.bout}, {31'd0, expBout});
        checkOutput({tag, " ovf"}, {31'd0, bus.ovf}, {31'd0, expOvf});
        checkOutput({tag, " zero"}, {31'd0, bus.zero}, {31'd0, expZero});
        for (int i = 0; i < holdCycles; i++) begin
            if (noise) begin
                bus.a        = 8'hAA;
                bus.b        = 8'h55;
                bus.bin      = 1'b1;
                bus.in_valid = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            checkOutput({tag, " hold out_valid"}, {31'd0, bus.out_valid}, 32'd1);
            checkOutput({tag, " hold in_ready"}, {31'd0, bus.in_ready}, 32'd0);
            checkOutput({tag, " hold diff"}, {24'd0, bus.diff}, {24'd0, expDiff});
            checkOutput({tag, " hold bout"}, {31'd0, bus.bout}, {31'd0, expBout});
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " release out_valid"}, {31'd0, bus.out_valid}, 32'd0);
        checkOutput({tag, " release in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        checkOutput({tag, " diff kept"}, {24'd0, bus.diff}, {24'd0, expDiff});
    endtask

    initial begin
        logic [8:0] wide;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbin;
        logic [7:0] eDiff;
        logic       eOvf;
        int         gap;

        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("reset diff", {24'd0, bus.diff}, 32'd0);
        checkOutput("reset flags", {29'd0, bus.bout, bus.ovf, bus.zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus("basic", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus("ripple", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("ovf", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("zero", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0);
        applyStimulus("negovf", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        applyStimulus("hold", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b1);

        // Abort an operation while the second digit is being computed.
        @(negedge clk);
        bus.a         = 8'h35;
        bus.b         = 8'h12;
        bus.bin       = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", {31'd0, bus.out_valid}, 32'd0);
        checkOutput("midreset in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("midreset diff", {24'd0, bus.diff}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("after-reset", 8'h35, 8'h12, 1'b0, 8'h23, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);

        for (int n = 0; n < 150; n++) begin
            ra    = 8'($urandom);
            rb    = 8'($urandom);
            rbin  = 1'($urandom);
            wide  = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
            eDiff = wide[7:0];
            eOvf  = (ra[7] != rb[7]) && (eDiff[7] != ra[7]);
            gap   = int'($urandom_range(0, 3));
            repeat (gap) @(negedge clk);
            applyStimulus("random", ra, rb, rbin, eDiff, wide[8], eOvf, (eDiff == 8'd0),
                          1'b1, int'($urandom_range(0, 2)), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL global-timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
